pipe_run_ctrl: RTL and testbench

- Run/step controller placed between the board-level clock/reset and top_pipe.
- Holds the pipeline in reset for a parametrised number of cycles after reset.
- Then gates pipeline advance with a clock-enable in three modes:
  - free-run;
  - single-step;
  - halted, entered when the pipeline reports a halt instruction or a watchdog expires.
- Keeps a saturating cycle counter.

---
 rtl/pipe_run_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_run_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_run_ctrl.sv
// Run/step controller in front of top_pipe: holds the pipeline in reset after
// reset/restart, then gates advance with a clock-enable (free-run, single-step, halted).
module pipe_run_ctrl #(
    parameter int NB_data    = 32,
    parameter int RST_CYCLES = 3,
    parameter int NB_rst     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_req,
    input  logic               step_req,
    input  logic               stop_req,
    input  logic               restart,
    input  logic               halt_in,
    input  logic [NB_data-1:0] wdog_limit,
    output logic               pipe_reset,
    output logic               pipe_en,
    output logic [NB_data-1:0] cycle_cnt,
    output logic [2:0]         state,
    output logic               halted,
    output logic               timeout
);

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        RUN      = 3'd2,
        STEP     = 3'd3,
        HALTED   = 3'd4
    } state_t;

    localparam logic [NB_rst-1:0]  HOLD_LAST = NB_rst'(RST_CYCLES - 1);
    localparam logic [NB_data-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [NB_rst-1:0]  hold_q, hold_d;
    logic [NB_data-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [NB_data-1:0] cnt_inc;
    logic               timeout_q, timeout_d;
    logic               pipe_reset_q, pipe_reset_d;
    logic               pipe_en_q, pipe_en_d;
    logic               halted_q, halted_d;
    logic               wdog_hit;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        timeout_d   = timeout_q;
        cnt_inc     = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + NB_data'(1);
        cycle_cnt_d = pipe_en_q ? cnt_inc : cycle_cnt_q;
        // The watchdog compares against the count this enabled cycle will produce.
        wdog_hit    = (wdog_limit != '0) && (cnt_inc == wdog_limit);

        if (restart) begin
            state_d     = RST_HOLD;
            hold_d      = '0;
            cycle_cnt_d = '0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    if (hold_q == HOLD_LAST) state_d = IDLE;
                    else                     hold_d  = hold_q + NB_rst'(1);
                end
                IDLE: begin
                    if (run_req)       state_d = RUN;
                    else if (step_req) state_d = STEP;
                end
                RUN, STEP: begin
                    if (halt_in || wdog_hit) begin
                        state_d   = HALTED;
                        timeout_d = timeout_q | wdog_hit;
                    end else if (state_q == STEP || stop_req) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        pipe_reset_d = (state_d == RST_HOLD);
        pipe_en_d    = (state_d == RUN) || (state_d == STEP);
        halted_d     = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RST_HOLD;
            hold_q       <= '0;
            cycle_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            pipe_reset_q <= 1'b1;
            pipe_en_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_cnt_q  <= cycle_cnt_d;
            timeout_q    <= timeout_d;
            pipe_reset_q <= pipe_reset_d;
            pipe_en_q    <= pipe_en_d;
            halted_q     <= halted_d;
        end
    end

    assign state      = state_q;
    assign pipe_reset = pipe_reset_q;
    assign pipe_en    = pipe_en_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: directed scenarios plus randomized
// requests compared every cycle against a rule-level reference model.
module tb_pipe_run_ctrl;

    localparam int NB_data    = 4;
    localparam int RST_CYCLES = 3;
    localparam int CNT_MAX    = (1 << NB_data) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               run_req, step_req, stop_req, restart, halt_in;
    logic [NB_data-1:0] wdog_limit;
    logic               pipe_reset, pipe_en, halted, timeout;
    logic [NB_data-1:0] cycle_cnt;
    logic [2:0]         state;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: state numbers follow the published output encoding.
    int mState, mHold, mCnt;
    bit mTimeout;

    pipe_run_ctrl #(.NB_data(NB_data), .RST_CYCLES(RST_CYCLES), .NB_rst(4)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
        .stop_req(stop_req), .restart(restart), .halt_in(halt_in),
        .wdog_limit(wdog_limit), .pipe_reset(pipe_reset), .pipe_en(pipe_en),
        .cycle_cnt(cycle_cnt), .state(state), .halted(halted), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0; mHold = 0; mCnt = 0; mTimeout = 0;
    endtask

    task automatic modelStep();
        bit en, wd;
        int inc;
        en  = (mState == 2) || (mState == 3);
        inc = (mCnt < CNT_MAX) ? mCnt + 1 : mCnt;
        if (restart) begin
            modelReset();
            return;
        end
        if (en) mCnt = inc;
        case (mState)
            0: if (mHold == RST_CYCLES - 1) mState = 1; else mHold++;
            1: if (run_req) mState = 2; else if (step_req) mState = 3;
            2, 3: begin
                wd = (wdog_limit != 0) && (inc == int'(wdog_limit));
                if (halt_in || wd) begin
                    mState = 4;
                    if (wd) mTimeout = 1;
                end else if (mState == 3 || stop_req) mState = 1;
            end
            default: ;
        endcase
    endtask

    task automatic checkAll();
        checkOutput("state", state, mState);
        checkOutput("pipe_reset", pipe_reset, mState == 0);
        checkOutput("pipe_en", pipe_en, (mState == 2) || (mState == 3));
        checkOutput("cycle_cnt", cycle_cnt, mCnt);
        checkOutput("halted", halted, mState == 4);
        checkOutput("timeout", timeout, mTimeout);
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit st, input bit rs, input bit h);
        run_req = r; step_req = s; stop_req = st; restart = rs; halt_in = h;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic doRestart();
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (RST_CYCLES) tick();
        checkOutput("restart_to_idle", state, 1);
    endtask

    initial begin
        int enCount, rstCount;
        bit seen;

        reset = 1'b1;
        wdog_limit = '0;
        applyStimulus(0, 0, 0, 0, 0);
        modelReset();
        #2;
        checkAll();
        #10 reset = 1'b0;

        // Reset hold length
        rstCount = 0;
        for (int i = 0; i < 6; i++) begin
            if (pipe_reset) rstCount++;
            tick();
        end
        checkOutput("rst_hold_edges", rstCount, RST_CYCLES);
        checkOutput("post_reset_cnt", cycle_cnt, 0);

        // Free-run for 10 enabled cycles then stop
        enCount = 0;
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        if (pipe_en) enCount++;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (pipe_en) enCount++;
        end
        applyStimulus(0, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("run10_en_cycles", enCount, 10);
        checkOutput("run10_cnt", cycle_cnt, 10);
        checkOutput("run10_idle", state, 1);

        // Held step request gives one pulse every two cycles
        doRestart();
        enCount = 0;
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pipe_en) enCount++;
        end
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("step_pulses", enCount, 3);
        checkOutput("step_cnt", cycle_cnt, 3);

        // Watchdog
        doRestart();
        wdog_limit = 4'd5;
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (halted) seen = 1;
        end
        checkOutput("wdog_halt_seen", seen, 1);
        checkOutput("wdog_cnt", cycle_cnt, 5);
        checkOutput("wdog_timeout", timeout, 1);
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("halted_ignores_run", state, 4);

        // halt_in and stop_req together, then restart
        wdog_limit = '0;
        doRestart();
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) tick();
        applyStimulus(0, 0, 1, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("halt_stop_state", state, 4);
        checkOutput("halt_stop_timeout", timeout, 0);
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("restart_cnt", cycle_cnt, 0);
        checkOutput("restart_halted", halted, 0);
        rstCount = 0;
        for (int i = 0; i < 5; i++) begin
            if (pipe_reset) rstCount++;
            tick();
        end
        checkOutput("restart_hold_edges", rstCount, RST_CYCLES);

        // Asynchronous reset between edges
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (7) tick();
        checkOutput("pre_async_cnt", cycle_cnt, 7);
        #3 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        #1 reset = 1'b0;
        repeat (RST_CYCLES) tick();

        // Counter saturation
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (20) tick();
        checkOutput("sat_cnt", cycle_cnt, CNT_MAX);
        checkOutput("sat_running", pipe_en, 1);

        // Randomized requests
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) wdog_limit = NB_data'($urandom_range(0, CNT_MAX));
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 11) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
